// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Booth recoding of one 3-bit multiplier window
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PM   = 3'd1,
        P2M  = 3'd2,
        MM   = 3'd3,
        M2M  = 3'd4
    } rop_e;

    // Extended operand width: W+1 rounded up to an even number of bits,
    // so an unsigned operand gets a zero sign bit and pairs divide evenly.
    function automatic int ext_width(input int w);
        return ((w + 2) / 2) * 2;
    endfunction

endpackage

// File: rtl/booth_radix4_mult_if.sv
// Start/busy/done handshake and operand/product bus of the Booth multiplier.
interface booth_radix4_mult_if #(parameter int W = 8);
    logic           start;
    logic           signed_en;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    modport master (output start, signed_en, a, b,
                    input  ready, busy, done, p);
    modport slave  (input  start, signed_en, a, b,
                    output ready, busy, done, p);
endinterface

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: 3-bit window {Q[1],Q[0],Q_1} -> operation and the
// matching accumulator-width addend (0, +M, +2M, -M, -2M).
module booth_r4_recoder
    import booth_pkg::*;
#(
    parameter int EW = 10
) (
    input  logic [2:0]    win,
    input  logic [EW-1:0] m,
    output rop_e          op,
    output logic [EW+1:0] addend
);
    localparam int AW = EW + 2;
    localparam logic [AW-1:0] ONE = AW'(1);

    logic [AW-1:0] m1;
    logic [AW-1:0] m2;

    // Two guard bits keep +/-2M representable in the accumulator
    assign m1 = {{2{m[EW-1]}}, m};
    assign m2 = {m1[AW-2:0], 1'b0};

    // Window decode
    always_comb begin
        case (win)
            3'b001, 3'b010: op = PM;
            3'b011:         op = P2M;
            3'b100:         op = M2M;
            3'b101, 3'b110: op = MM;
            default:        op = ZERO;
        endcase
    end

    // Addend select; negation is two's complement in accumulator width
    always_comb begin
        case (op)
            PM:      addend = m1;
            P2M:     addend = m2;
            MM:      addend = ~m1 + ONE;
            M2M:     addend = ~m2 + ONE;
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier, 2 multiplier bits retired per clock.
// Optional macro BOOTH_EARLY_TERM_EN: finish early once the remaining
// multiplier bits would only recode to zero.
module booth_radix4_mult
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input logic                clk,
    input logic                reset,
    booth_radix4_mult_if.slave bus
);
    localparam int EW = ext_width(W);
    localparam int NI = EW / 2;
    localparam int CW = $clog2(NI + 1);
    localparam int AW = EW + 2;
    localparam int PW = 2 * W;
    localparam logic [CW-1:0] NI_C  = CW'(NI);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    state_e         state_q, state_d;
    logic [AW-1:0]  acc_q,   acc_d;
    logic [EW-1:0]  m_q,     m_d;
    logic [EW-1:0]  q_q,     q_d;
    logic           q1_q,    q1_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [PW-1:0]  p_q,     p_d;
    logic           done_q,  done_d;

    rop_e           rec_op;
    logic [AW-1:0]  addend;
    logic [AW-1:0]  sum;
    logic [AW+EW:0] step_sh;

    booth_r4_recoder #(.EW(EW)) u_rec (
        .win    ({q_q[1:0], q1_q}),
        .m      (m_q),
        .op     (rec_op),
        .addend (addend)
    );

    // One iteration: add the recoded multiple, then shift {A,Q,Q_1} right by 2
    always_comb begin
        sum     = (rec_op == ZERO) ? acc_q : acc_q + addend;
        step_sh = $signed({sum, q_q, q1_q}) >>> 2;
    end

`ifdef BOOTH_EARLY_TERM_EN
    logic [EW-1:0]   tail_mask;
    logic            tail_same;
    logic [AW+EW-1:0] skip_sh;

    // Unprocessed multiplier bits are the low 2*cnt bits of Q plus Q_1;
    // all-equal means every remaining window recodes to zero, so the rest
    // of the run collapses into one arithmetic shift.
    always_comb begin
        for (int i = 0; i < EW; i++) begin
            tail_mask[i] = (i < 2 * int'(cnt_q));
        end
        tail_same = (((q_q & tail_mask) == '0)        && !q1_q) ||
                    (((q_q & tail_mask) == tail_mask) &&  q1_q);
        skip_sh   = $signed({acc_q, q_q}) >>> {cnt_q, 1'b0};
    end
`endif

    // Controller and datapath next state
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Extension bakes signed_en into the operands, so the
                    // mode itself need not be kept for the run.
                    m_d     = {{(EW-W){bus.signed_en & bus.a[W-1]}}, bus.a};
                    q_d     = {{(EW-W){bus.signed_en & bus.b[W-1]}}, bus.b};
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    cnt_d   = NI_C;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    p_d     = PW'({acc_q, q_q});
                    done_d  = 1'b1;
                    state_d = DONE;
                end
`ifdef BOOTH_EARLY_TERM_EN
                else if (tail_same) begin
                    {acc_d, q_d} = skip_sh;
                    q1_d         = 1'b0;
                    cnt_d        = '0;
                end
`endif
                else begin
                    {acc_d, q_d, q1_d} = step_sh;
                    cnt_d              = cnt_q - ONE_C;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready = (state_q == IDLE) || (state_q == DONE);
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.p     = p_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Scoreboard bench for booth_radix4_mult (W=8): directed vectors with
// hand-computed products, checked by an independent done monitor.
module tb_booth_radix4_mult;
    localparam int W   = 8;
    localparam int LAT = 6;   // accept edge to done, full-latency build

    typedef struct {
        logic [15:0] p;
        int          acc;
        bit          fast;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    exp_t sb[$];
    exp_t e;
    int   lat;
    bit   prev_done = 1'b0;

    booth_radix4_mult_if #(.W(W)) bus ();

    booth_radix4_mult #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Hold start until the DUT is ready, record the accept edge, then release
    task automatic issue(input logic [7:0] ai, input logic [7:0] bi, input logic s,
                         input logic [15:0] pe, input bit fast);
        int   n = 0;
        exp_t x;
        @(negedge clk);
        bus.a = ai; bus.b = bi; bus.signed_en = s; bus.start = 1'b1;
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            nvec++; nerr++;
            $display("FAIL accept_timeout: ready stayed 0 for %0d cycles", n);
            bus.start = 1'b0;
        end else begin
            x.p = pe; x.acc = cyc + 1; x.fast = fast;
            sb.push_back(x);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    // Monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        if (reset) begin
            prev_done = 1'b0;
        end else begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL unexpected_done: p=%0h with empty scoreboard", bus.p);
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - e.acc;
                    chk("product", {16'd0, bus.p}, {16'd0, e.p});
                    nvec++;
`ifdef BOOTH_EARLY_TERM_EN
                    if (lat < 2 || lat > LAT || (e.fast && lat >= LAT)) begin
                        nerr++;
                        $display("FAIL latency: got %0d expected 2..%0d%s", lat, LAT,
                                 e.fast ? " (shortened)" : "");
                    end
`else
                    if (lat != LAT) begin
                        nerr++;
                        $display("FAIL latency: got %0d expected %0d", lat, LAT);
                    end
`endif
                end
                if (prev_done) begin
                    nvec++; nerr++;
                    $display("FAIL done_pulse: done high %0d consecutive cycles, expected 1", 2);
                end
            end
            prev_done = bus.done;
        end
    end

    initial begin
        bus.start = 1'b0; bus.signed_en = 1'b0; bus.a = '0; bus.b = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_p",     {16'd0, bus.p},     32'd0);
        chk("reset_done",  {31'd0, bus.done},  32'd0);
        chk("reset_busy",  {31'd0, bus.busy},  32'd0);
        chk("reset_ready", {31'd0, bus.ready}, 32'd1);
        reset = 1'b0;

        // Boundaries and sign modes
        issue(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0);  // -128 * -128
        issue(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0);  // 255 * 255
        issue(8'hFF, 8'h7F, 1'b1, 16'hFF81, 1'b0);  // -1 * 127
        issue(8'd100, 8'd1, 1'b1, 16'h0064, 1'b1);  // 100 * 1
        drain();

        // start pulsed during RUN with other operands must be ignored
        issue(8'd12, 8'd12, 1'b0, 16'h0090, 1'b0);
        @(negedge clk); bus.a = 8'd99; bus.b = 8'd99; bus.signed_en = 1'b1; bus.start = 1'b1;
        @(negedge clk); bus.a = 8'd77; bus.b = 8'd55; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        drain();

        // Back-to-back: second start held high through DONE
        issue(8'h7F, 8'h7F, 1'b1, 16'h3F01, 1'b0);  // 127 * 127
        issue(8'd3,  8'hFB, 1'b1, 16'hFFF1, 1'b0);  // 3 * -5
        drain();

        issue(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b0);  // -128 * 127
        issue(8'h80, 8'h02, 1'b0, 16'h0100, 1'b0);  // 128 * 2 unsigned
        issue(8'hFD, 8'hF9, 1'b1, 16'h0015, 1'b0);  // -3 * -7
        issue(8'd200, 8'd3, 1'b0, 16'h0258, 1'b0);  // 200 * 3
        issue(8'h01, 8'hFF, 1'b1, 16'hFFFF, 1'b0);  // 1 * -1
        issue(8'd0, 8'd200, 1'b0, 16'h0000, 1'b0);  // 0 * 200
        drain();

        // Reset during the 3rd RUN cycle aborts the operation
        @(negedge clk);
        bus.a = 8'd5; bus.b = 8'h55; bus.signed_en = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_p",     {16'd0, bus.p},     32'd0);
        chk("abort_done",  {31'd0, bus.done},  32'd0);
        chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        chk("abort_busy",  {31'd0, bus.busy},  32'd0);
        repeat (10) @(negedge clk);

        issue(8'd170, 8'd85, 1'b0, 16'h3872, 1'b0); // 170 * 85
        drain();
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
